// File: rtl/stream_channel_ctrl.sv
// rtl/stream_channel_ctrl.sv - single-clock stream channel controller with TX/RX FIFOs and completion interrupt

module stream_channel_ctrl_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr, rptr;
   logic         full, empty, wr_en, rd_en;

   // The extra pointer bit separates full from empty when the index bits match.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign dout  = mem[rptr[AW-1:0]];
   assign level = wptr - rptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[AW-1:0]] <= din;
   end
endmodule

module stream_channel_ctrl #(
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 32
) (
   input  logic              i_user_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [LEN_W-1:0]  i_tx_len,
   input  logic [LEN_W-1:0]  i_rx_len,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_overflow,
   output logic [LEN_W-1:0]  o_tx_cnt,
   output logic [LEN_W-1:0]  o_rx_cnt,
   input  logic              i_host_data_valid,
   input  logic [DATA_W-1:0] i_host_data,
   output logic              o_host_ack,
   output logic              o_ustr_data_valid,
   output logic [DATA_W-1:0] o_ustr_data,
   input  logic              i_ustr_ack,
   input  logic              i_ustr_data_valid,
   input  logic [DATA_W-1:0] i_ustr_data,
   output logic              o_ustr_ack,
   output logic              o_host_wr_valid,
   output logic [DATA_W-1:0] o_host_wr_data,
   input  logic              i_host_wr_ack,
   output logic              o_intr_req,
   input  logic              i_intr_ack
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, INTR} state_t;

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  tx_len_r, rx_len_r, host_in_cnt, rx_cnt_nxt, rx_len_nxt;
   logic [AW:0]       tx_level, rx_level, rx_level_nxt;
   logic [DATA_W-1:0] tx_head, rx_head;
   logic              tx_full, tx_empty, rx_empty;
   logic              tx_push, tx_pop, rx_push, rx_pop;
   logic              start_ok, ovf_set, ack_nxt;

   stream_channel_ctrl_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(i_user_clk), .rst(i_rst), .push(tx_push), .din(i_host_data),
      .pop(tx_pop), .dout(tx_head), .level(tx_level)
   );

   stream_channel_ctrl_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(i_user_clk), .rst(i_rst), .push(rx_push), .din(i_ustr_data),
      .pop(rx_pop), .dout(rx_head), .level(rx_level)
   );

   assign tx_full  = (tx_level == LVL_FULL);
   assign tx_empty = (tx_level == '0);
   assign rx_empty = (rx_level == '0);

   assign start_ok          = i_start && (state == IDLE);
   assign o_host_ack        = (state == RUN) && !tx_full && (host_in_cnt < tx_len_r);
   assign tx_push           = i_host_data_valid && o_host_ack;
   assign o_ustr_data_valid = !tx_empty;
   assign o_ustr_data       = tx_empty ? '0 : tx_head;
   assign tx_pop            = o_ustr_data_valid && i_ustr_ack;
   assign rx_push           = i_ustr_data_valid && o_ustr_ack;
   assign o_host_wr_valid   = !rx_empty;
   assign o_host_wr_data    = rx_empty ? '0 : rx_head;
   assign rx_pop            = o_host_wr_valid && i_host_wr_ack;
   assign ovf_set           = i_ustr_data_valid && !o_ustr_ack &&
                              !((state == IDLE) && (o_rx_cnt == rx_len_r));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start) state_nxt = RUN;
         RUN:     if ((o_tx_cnt == tx_len_r) && (o_rx_cnt == rx_len_r)) state_nxt = FLUSH;
         FLUSH:   if (rx_empty) state_nxt = INTR;
         INTR:    if (i_intr_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // o_ustr_ack is registered, so it is computed from next-cycle state, level and count
   // to avoid accepting a word past rx_len or into a full FIFO.
   assign rx_level_nxt = rx_level + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rx_pop};
   assign rx_cnt_nxt   = start_ok ? '0 : o_rx_cnt + {{(LEN_W-1){1'b0}}, rx_push};
   assign rx_len_nxt   = start_ok ? i_rx_len : rx_len_r;
   assign ack_nxt      = (state_nxt == RUN) && (rx_level_nxt != LVL_FULL) &&
                         (rx_cnt_nxt < rx_len_nxt);

   always_ff @(posedge i_user_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         tx_len_r    <= '0;
         rx_len_r    <= '0;
         host_in_cnt <= '0;
         o_tx_cnt    <= '0;
         o_rx_cnt    <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_overflow  <= 1'b0;
         o_ustr_ack  <= 1'b0;
         o_intr_req  <= 1'b0;
      end else begin
         state      <= state_nxt;
         o_ustr_ack <= ack_nxt;
         o_done     <= (state == FLUSH) && (state_nxt == INTR);
         if (start_ok) begin
            tx_len_r    <= i_tx_len;
            rx_len_r    <= i_rx_len;
            host_in_cnt <= '0;
            o_tx_cnt    <= '0;
            o_rx_cnt    <= '0;
            o_overflow  <= 1'b0;
            o_busy      <= 1'b1;
         end else begin
            if (tx_push) host_in_cnt <= host_in_cnt + 1'b1;
            if (tx_pop && (o_tx_cnt != tx_len_r)) o_tx_cnt <= o_tx_cnt + 1'b1;
            if (rx_push && (o_rx_cnt != rx_len_r)) o_rx_cnt <= o_rx_cnt + 1'b1;
            if (ovf_set) o_overflow <= 1'b1;
         end
         if ((state == FLUSH) && (state_nxt == INTR)) o_intr_req <= 1'b1;
         if ((state == INTR) && i_intr_ack) begin
            o_intr_req <= 1'b0;
            o_busy     <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_stream_channel_ctrl.sv
// tb/tb_stream_channel_ctrl.sv - directed self-checking bench for stream_channel_ctrl

module tb_stream_channel_ctrl;
   localparam int DW = 64;
   localparam int LW = 32;

   logic          i_user_clk = 1'b0;
   logic          i_rst = 1'b1, i_start = 1'b0;
   logic [LW-1:0] i_tx_len = '0, i_rx_len = '0;
   logic          o_busy, o_done, o_overflow;
   logic [LW-1:0] o_tx_cnt, o_rx_cnt;
   logic          i_host_data_valid = 1'b0;
   logic [DW-1:0] i_host_data = '0;
   logic          o_host_ack, o_ustr_data_valid;
   logic [DW-1:0] o_ustr_data;
   logic          i_ustr_ack = 1'b0, i_ustr_data_valid = 1'b0;
   logic [DW-1:0] i_ustr_data = '0;
   logic          o_ustr_ack, o_host_wr_valid;
   logic [DW-1:0] o_host_wr_data;
   logic          i_host_wr_ack = 1'b0;
   logic          o_intr_req;
   logic          i_intr_ack = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   always #5 i_user_clk = ~i_user_clk;

   stream_channel_ctrl #(.DATA_W(DW), .FIFO_DEPTH(16), .LEN_W(LW)) dut (
      .i_user_clk(i_user_clk), .i_rst(i_rst), .i_start(i_start),
      .i_tx_len(i_tx_len), .i_rx_len(i_rx_len),
      .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow),
      .o_tx_cnt(o_tx_cnt), .o_rx_cnt(o_rx_cnt),
      .i_host_data_valid(i_host_data_valid), .i_host_data(i_host_data), .o_host_ack(o_host_ack),
      .o_ustr_data_valid(o_ustr_data_valid), .o_ustr_data(o_ustr_data), .i_ustr_ack(i_ustr_ack),
      .i_ustr_data_valid(i_ustr_data_valid), .i_ustr_data(i_ustr_data), .o_ustr_ack(o_ustr_ack),
      .o_host_wr_valid(o_host_wr_valid), .o_host_wr_data(o_host_wr_data), .i_host_wr_ack(i_host_wr_ack),
      .o_intr_req(o_intr_req), .i_intr_ack(i_intr_ack)
   );

   task automatic tick();
      @(negedge i_user_clk);
   endtask

   task automatic do_start(input logic [LW-1:0] tx, input logic [LW-1:0] rx);
      i_start = 1'b1; i_tx_len = tx; i_rx_len = rx;
      tick();
      i_start = 1'b0;
   endtask

   task automatic wait_intr(output bit seen);
      int n = 0;
      while (!o_intr_req && n < 100) begin tick(); n++; end
      seen = o_intr_req;
   endtask

   task automatic pulse_intr_ack();
      i_intr_ack = 1'b1; tick(); i_intr_ack = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; tick(); tick();
      vectors++;
      if ({o_busy, o_done, o_overflow, o_tx_cnt, o_rx_cnt, o_host_ack, o_ustr_data_valid, o_ustr_data,
           o_ustr_ack, o_host_wr_valid, o_host_wr_data, o_intr_req} !== '0) begin
         miscompares++; $display("FAIL reset_outputs: some output nonzero, busy=%b cnt=%0d/%0d intr=%b", o_busy, o_tx_cnt, o_rx_cnt, o_intr_req);
      end
      i_rst = 1'b0; tick();
      vectors++;
      if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b want 0", o_busy); end
   endtask

   task automatic test_echo();
      logic [DW-1:0] echo_q[$];
      int hi = 0, ut = 0, rw = 0, dones = 0, cyc = 0;
      bit seen;
      i_ustr_ack = 1'b1; i_host_wr_ack = 1'b1;
      do_start(8, 8);
      while (!o_intr_req && cyc < 200) begin
         if (o_done) dones++;
         i_host_data_valid = (hi < 8); i_host_data = DW'(hi);
         if (i_host_data_valid && o_host_ack) hi++;
         i_ustr_data_valid = (echo_q.size() > 0);
         i_ustr_data = (echo_q.size() > 0) ? echo_q[0] : '0;
         if (i_ustr_data_valid && o_ustr_ack) void'(echo_q.pop_front());
         if (o_ustr_data_valid) begin
            vectors++;
            if (o_ustr_data !== DW'(ut)) begin miscompares++; $display("FAIL echo_to_user[%0d]: got %0h want %0h", ut, o_ustr_data, ut); end
            echo_q.push_back(o_ustr_data + DW'(1)); ut++;
         end
         if (o_host_wr_valid) begin
            vectors++;
            if (o_host_wr_data !== DW'(rw + 1)) begin miscompares++; $display("FAIL echo_to_host[%0d]: got %0h want %0h", rw, o_host_wr_data, rw + 1); end
            rw++;
         end
         tick(); cyc++;
      end
      i_host_data_valid = 1'b0; i_ustr_data_valid = 1'b0;
      if (o_done) dones++;
      vectors++;
      if (ut != 8 || rw != 8) begin miscompares++; $display("FAIL echo_word_counts: user=%0d host=%0d want 8/8", ut, rw); end
      vectors++;
      if (o_tx_cnt !== 8 || o_rx_cnt !== 8 || o_overflow !== 1'b0) begin
         miscompares++; $display("FAIL echo_final_regs: tx=%0d rx=%0d ovf=%b want 8 8 0", o_tx_cnt, o_rx_cnt, o_overflow);
      end
      tick(); tick();
      vectors++;
      if (o_intr_req !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b1) begin
         miscompares++; $display("FAIL echo_intr_held: intr=%b done=%b busy=%b want 1 0 1", o_intr_req, o_done, o_busy);
      end
      vectors++;
      if (dones != 1) begin miscompares++; $display("FAIL echo_done_pulses: got %0d want 1", dones); end
      pulse_intr_ack();
      vectors++;
      if (o_intr_req !== 1'b0 || o_busy !== 1'b0) begin miscompares++; $display("FAIL echo_intr_ack: intr=%b busy=%b want 0 0", o_intr_req, o_busy); end
      seen = 1'b0;
   endtask

   task automatic test_tx_full();
      int hi = 0, ut = 0, cyc = 0;
      bit seen;
      i_ustr_ack = 1'b0; i_host_wr_ack = 1'b1;
      do_start(40, 0);
      for (int c = 0; c < 25; c++) begin
         i_host_data_valid = (hi < 40); i_host_data = DW'(1000 + hi);
         if (i_host_data_valid && o_host_ack) hi++;
         tick();
      end
      vectors++;
      if (hi != 16 || o_host_ack !== 1'b0) begin miscompares++; $display("FAIL txfull_stall: accepted=%0d ack=%b want 16 0", hi, o_host_ack); end
      vectors++;
      if (o_ustr_data_valid !== 1'b1 || o_ustr_data !== DW'(1000)) begin
         miscompares++; $display("FAIL txfull_hold: valid=%b data=%0d want 1 1000", o_ustr_data_valid, o_ustr_data);
      end
      i_ustr_ack = 1'b1;
      while (ut < 40 && cyc < 300) begin
         i_host_data_valid = (hi < 40); i_host_data = DW'(1000 + hi);
         if (i_host_data_valid && o_host_ack) hi++;
         if (o_ustr_data_valid) begin
            vectors++;
            if (o_ustr_data !== DW'(1000 + ut)) begin miscompares++; $display("FAIL txfull_order[%0d]: got %0d want %0d", ut, o_ustr_data, 1000 + ut); end
            ut++;
         end
         tick(); cyc++;
      end
      i_host_data_valid = 1'b0;
      vectors++;
      if (o_tx_cnt !== 40 || ut != 40) begin miscompares++; $display("FAIL txfull_count: tx_cnt=%0d seen=%0d want 40", o_tx_cnt, ut); end
      wait_intr(seen);
      vectors++;
      if (!seen) begin miscompares++; $display("FAIL txfull_intr: got 0 want 1"); end
      pulse_intr_ack();
   endtask

   task automatic test_rx_overflow();
      int acc = 0, rw = 0, cyc = 0;
      bit seen;
      i_ustr_ack = 1'b0; i_host_wr_ack = 1'b0;
      do_start(0, 4);
      for (int k = 0; k < 20; k++) begin
         i_ustr_data_valid = 1'b1; i_ustr_data = DW'(2000 + k);
         if (o_ustr_ack) acc++;
         tick();
      end
      i_ustr_data_valid = 1'b0;
      vectors++;
      if (acc != 4 || o_rx_cnt !== 4 || o_ustr_ack !== 1'b0) begin
         miscompares++; $display("FAIL rxovf_accept: accepted=%0d rx_cnt=%0d ack=%b want 4 4 0", acc, o_rx_cnt, o_ustr_ack);
      end
      vectors++;
      if (o_overflow !== 1'b1) begin miscompares++; $display("FAIL rxovf_flag: got %b want 1", o_overflow); end
      vectors++;
      if (o_intr_req !== 1'b0 || o_busy !== 1'b1 || o_host_wr_valid !== 1'b1) begin
         miscompares++; $display("FAIL rxovf_flush_hold: intr=%b busy=%b wr_valid=%b want 0 1 1", o_intr_req, o_busy, o_host_wr_valid);
      end
      i_host_wr_ack = 1'b1;
      while (rw < 4 && cyc < 50) begin
         if (o_host_wr_valid) begin
            vectors++;
            if (o_host_wr_data !== DW'(2000 + rw)) begin miscompares++; $display("FAIL rxovf_drain[%0d]: got %0d want %0d", rw, o_host_wr_data, 2000 + rw); end
            rw++;
         end
         tick(); cyc++;
      end
      wait_intr(seen);
      vectors++;
      if (!seen || rw != 4) begin miscompares++; $display("FAIL rxovf_intr: intr=%b drained=%0d want 1 4", seen, rw); end
      pulse_intr_ack();
   endtask

   task automatic test_zero_len();
      i_host_data_valid = 1'b1; i_host_data = DW'(77);
      do_start(0, 0);
      vectors++;
      if (o_busy !== 1'b1 || o_done !== 1'b0 || o_overflow !== 1'b0) begin
         miscompares++; $display("FAIL zero_c1: busy=%b done=%b ovf=%b want 1 0 0", o_busy, o_done, o_overflow);
      end
      i_intr_ack = 1'b1;
      tick(); i_intr_ack = 1'b0;
      vectors++;
      if (o_done !== 1'b0 || o_busy !== 1'b1 || o_host_ack !== 1'b0 || o_ustr_ack !== 1'b0) begin
         miscompares++; $display("FAIL zero_c2: done=%b busy=%b hack=%b uack=%b want 0 1 0 0", o_done, o_busy, o_host_ack, o_ustr_ack);
      end
      tick();
      vectors++;
      if (o_done !== 1'b1 || o_intr_req !== 1'b1) begin miscompares++; $display("FAIL zero_c3_done: done=%b intr=%b want 1 1", o_done, o_intr_req); end
      tick();
      vectors++;
      if (o_done !== 1'b0 || o_intr_req !== 1'b1 || o_ustr_data_valid !== 1'b0 || o_tx_cnt !== 0) begin
         miscompares++; $display("FAIL zero_c4: done=%b intr=%b uvalid=%b tx=%0d want 0 1 0 0", o_done, o_intr_req, o_ustr_data_valid, o_tx_cnt);
      end
      i_host_data_valid = 1'b0;
      pulse_intr_ack();
   endtask

   task automatic test_start_ignored();
      int hi = 0, ut = 0, cyc = 0;
      bit seen;
      i_ustr_ack = 1'b0; i_host_wr_ack = 1'b1;
      do_start(3, 0);
      for (int c = 0; c < 6; c++) begin
         i_host_data_valid = (hi < 3); i_host_data = DW'(3000 + hi);
         if (i_host_data_valid && o_host_ack) hi++;
         tick();
      end
      i_host_data_valid = 1'b1; i_host_data = DW'(3999);
      i_start = 1'b1; i_tx_len = 10; i_rx_len = 5;
      tick();
      i_start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         vectors++;
         if (o_host_ack !== 1'b0 || o_ustr_ack !== 1'b0 || o_busy !== 1'b1 || o_tx_cnt !== 0) begin
            miscompares++; $display("FAIL restart_ignored[%0d]: hack=%b uack=%b busy=%b tx=%0d want 0 0 1 0", c, o_host_ack, o_ustr_ack, o_busy, o_tx_cnt);
         end
         tick();
      end
      i_host_data_valid = 1'b0; i_ustr_ack = 1'b1;
      while (ut < 3 && cyc < 50) begin
         if (o_ustr_data_valid) begin
            vectors++;
            if (o_ustr_data !== DW'(3000 + ut)) begin miscompares++; $display("FAIL restart_order[%0d]: got %0d want %0d", ut, o_ustr_data, 3000 + ut); end
            ut++;
         end
         tick(); cyc++;
      end
      wait_intr(seen);
      vectors++;
      if (!seen || o_tx_cnt !== 3 || o_rx_cnt !== 0) begin
         miscompares++; $display("FAIL restart_complete: intr=%b tx=%0d rx=%0d want 1 3 0", seen, o_tx_cnt, o_rx_cnt);
      end
      pulse_intr_ack();
   endtask

   task automatic test_reset_mid_run();
      int hi = 0, ut = 0, cyc = 0, dones = 0;
      bit seen;
      i_ustr_ack = 1'b0; i_host_wr_ack = 1'b1;
      do_start(8, 0);
      for (int c = 0; c < 7; c++) begin
         i_host_data_valid = (hi < 5); i_host_data = DW'(500 + hi);
         if (i_host_data_valid && o_host_ack) hi++;
         tick();
      end
      i_host_data_valid = 1'b0;
      i_rst = 1'b1; tick();
      vectors++;
      if ({o_busy, o_done, o_overflow, o_tx_cnt, o_rx_cnt, o_host_ack, o_ustr_data_valid, o_ustr_data,
           o_ustr_ack, o_host_wr_valid, o_host_wr_data, o_intr_req} !== '0 || hi != 5) begin
         miscompares++; $display("FAIL midrst_outputs: busy=%b uvalid=%b data=%0d intr=%b pushed=%0d want all 0, 5", o_busy, o_ustr_data_valid, o_ustr_data, o_intr_req, hi);
      end
      i_rst = 1'b0; tick();
      i_ustr_ack = 1'b1; hi = 0;
      do_start(2, 0);
      while (!o_intr_req && cyc < 100) begin
         if (o_done) dones++;
         i_host_data_valid = (hi < 2); i_host_data = DW'(600 + hi);
         if (i_host_data_valid && o_host_ack) hi++;
         if (o_ustr_data_valid) begin
            vectors++;
            if (o_ustr_data !== DW'(600 + ut)) begin miscompares++; $display("FAIL midrst_new_data[%0d]: got %0d want %0d", ut, o_ustr_data, 600 + ut); end
            ut++;
         end
         tick(); cyc++;
      end
      i_host_data_valid = 1'b0;
      seen = o_intr_req;
      vectors++;
      if (!seen || ut != 2 || o_tx_cnt !== 2 || dones != 0) begin
         miscompares++; $display("FAIL midrst_complete: intr=%b words=%0d tx=%0d early_done=%0d want 1 2 2 0", seen, ut, o_tx_cnt, dones);
      end
      pulse_intr_ack();
   endtask

   initial begin
      test_reset();
      test_echo();
      test_tx_full();
      test_rx_overflow();
      test_zero_len();
      test_start_ignored();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/stream_channel_ctrl.md
Name: stream_channel_ctrl

Overview:
Platform-side controller for one user stream channel. It is the counterpart of a user logic block's stream port.
- Host-to-user path: buffers host DMA words and presents them to user logic with a valid/ack handshake.
- User-to-host path: accepts user result words into a FIFO and forwards them to the host write path.
- Completion: tracks transfer lengths and raises an interrupt when the programmed transfer completes.

Parameters:
DATA_W, 64, stream word width
FIFO_DEPTH, 16, entries per FIFO (power of 2, >=4)
LEN_W, 32, width of length/count registers

Ports:
i_user_clk  in  1  clock; the only clock
i_rst  in  1  reset, synchronous, active-high
i_start  in  1  one-cycle start pulse; ignored while o_busy=1
i_tx_len  in  LEN_W  words to deliver to user, latched on accepted i_start
i_rx_len  in  LEN_W  words expected from user, latched on accepted i_start
o_busy  out  1  high from accepted start until interrupt acknowledged
o_done  out  1  one-cycle pulse on transfer completion
o_overflow  out  1  sticky; user word arrived while o_ustr_ack=0; cleared on accepted start
o_tx_cnt  out  LEN_W  words delivered to user this transfer
o_rx_cnt  out  LEN_W  words accepted from user this transfer
i_host_data_valid  in  1  host source word valid
i_host_data  in  DATA_W  host source word
o_host_ack  out  1  host source word accepted
o_ustr_data_valid  out  1  word to user valid
o_ustr_data  out  DATA_W  word to user
i_ustr_ack  in  1  user accepts word
i_ustr_data_valid  in  1  user result word valid
i_ustr_data  in  DATA_W  user result word
o_ustr_ack  out  1  controller ready for user result word
o_host_wr_valid  out  1  result word to host valid
o_host_wr_data  out  DATA_W  result word to host
i_host_wr_ack  in  1  host accepts result word
o_intr_req  out  1  completion interrupt request
i_intr_ack  in  1  interrupt acknowledge

Behaviour:
- Reset: every output is 0. FIFOs are emptied, counters are cleared, FSM goes to IDLE. Reset asserted mid-transfer aborts the transfer; no o_done or o_intr_req is generated.
- FSM states: IDLE, RUN, FLUSH, INTR.
  - IDLE -> RUN on i_start. Lengths are latched; o_tx_cnt, o_rx_cnt, o_overflow and the internal host-in count are cleared; o_busy is set.
  - RUN -> FLUSH when o_tx_cnt == tx_len and o_rx_cnt == rx_len.
  - FLUSH -> INTR when the RX FIFO is empty and no host write is pending. On this transition o_done pulses for 1 cycle and o_intr_req is set.
  - INTR -> IDLE on i_intr_ack, which clears o_intr_req and o_busy in the same edge.
- Zero-length transfer (tx_len = rx_len = 0): IDLE -> RUN -> FLUSH -> INTR takes 3 cycles after start, with o_done asserted in the 3rd cycle.
- Host-in: o_host_ack = (state==RUN) & !tx_full & (host_in_cnt < tx_len). A word is written to the TX FIFO when i_host_data_valid & o_host_ack.
- To user: o_ustr_data_valid = !tx_empty; o_ustr_data is the FIFO head (first-word-fall-through). A transfer completes on valid & i_ustr_ack, which pops the FIFO and increments o_tx_cnt.
- Hold rule: while o_ustr_data_valid=1 and i_ustr_ack=0, data and valid stay stable.
- From user: o_ustr_ack = (state==RUN) & !rx_full & (o_rx_cnt < rx_len), registered.
  - A word is accepted on i_ustr_data_valid & o_ustr_ack; o_rx_cnt increments.
  - i_ustr_data_valid while o_ustr_ack=0 drops the word and sets o_overflow. Exception: no overflow is flagged in IDLE when rx_len words are already received.
- To host: o_host_wr_valid = !rx_empty; data is the RX FIFO head. The FIFO pops on valid & i_host_wr_ack. Host writes continue in FLUSH.
- FIFO boundaries:
  - Simultaneous push and pop on a full FIFO is allowed.
  - Push on an empty FIFO makes the word visible the next cycle; pass-through latency is 1 cycle minimum.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are derived from an extra pointer bit.
- Counters saturate at their latched length and never wrap within a transfer.
- i_start during o_busy is ignored; no state or count changes.
- i_intr_ack outside INTR has no effect.
- Ordering: words leave each FIFO in arrival order; no reordering and no duplication.

Test Plan:
1. tx_len=rx_len=8, host sends words 0..7, user acks every cycle and echoes each word +1 one cycle later, host_wr_ack=1 -> o_ustr_data sequence 0..7; o_host_wr_data sequence 1..8; o_done pulses once; o_intr_req high until i_intr_ack; o_overflow=0.
2. tx_len=40, i_ustr_ack held 0 -> after 16 host words o_host_ack=0 (TX full). Release ack -> all 40 words are delivered in order and o_tx_cnt=40.
3. rx_len=4, i_host_wr_ack=0, user streams 20 continuous valid words -> o_ustr_ack drops after 4; o_rx_cnt=4; o_overflow=1; FSM stays in FLUSH until i_host_wr_ack=1 drains 4 words.
4. tx_len=rx_len=0, start -> o_done asserted 3 cycles after i_start; no stream handshakes occur.
5. Second i_start mid-RUN with different lengths -> ignored; the original lengths complete unchanged.
6. i_rst asserted with 5 words in the TX FIFO in RUN -> next cycle all outputs 0 and state IDLE. A following start with tx_len=2 delivers only the new host words.
